// File: rtl/os_systolic_tile_seq_if.sv
// Command, operand-stream and result-stream signals of the output-stationary tile.
// The tile connects to the slave side; a controller or bench connects to the master side.
interface os_systolic_tile_seq_if #(
  parameter int M           = 8,
  parameter int N           = 8,
  parameter int INPUT_WIDTH = 16,
  parameter int ACC_WIDTH   = 40,
  parameter int K_WIDTH     = 16
);
  localparam int ROW_IDX_WIDTH = (M > 1) ? $clog2(M) : 1;

  logic                       start;
  logic [K_WIDTH-1:0]         k_len;
  logic                       in_valid;
  logic                       in_ready;
  logic [M*INPUT_WIDTH-1:0]   in_row;
  logic [N*INPUT_WIDTH-1:0]   in_col;
  logic                       out_valid;
  logic                       out_ready;
  logic [ROW_IDX_WIDTH-1:0]   out_row_idx;
  logic [N*ACC_WIDTH-1:0]     out_data;
  logic                       busy;
  logic                       done;

  modport master (
    output start, k_len, in_valid, in_row, in_col, out_ready,
    input  in_ready, out_valid, out_row_idx, out_data, busy, done
  );

  modport slave (
    input  start, k_len, in_valid, in_row, in_col, out_ready,
    output in_ready, out_valid, out_row_idx, out_data, busy, done
  );
endinterface

// File: rtl/os_systolic_tile_seq.sv
// M x N output-stationary systolic tile: skews streamed operand vectors, accumulates
// C = A x B in place, flushes the wavefront, then drains one accumulator row per handshake.
module os_systolic_tile_seq #(
  parameter int M           = 8,
  parameter int N           = 8,
  parameter int INPUT_WIDTH = 16,
  parameter int ACC_WIDTH   = 40,
  parameter int K_WIDTH     = 16
) (
  input logic                  clk,
  input logic                  rst,
  os_systolic_tile_seq_if.slave bus
);
  localparam int ROW_IDX_WIDTH   = (M > 1) ? $clog2(M) : 1;
  localparam int FLUSH_LEN       = M + N - 2;
  localparam int FLUSH_CNT_WIDTH = $clog2(M + N) + 1;
  localparam int PROD_WIDTH      = 2 * INPUT_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    DRAIN,
    DONE
  } state_t;

  state_t state_reg, state_next;

  logic [K_WIDTH-1:0]         k_len_reg;
  logic [K_WIDTH-1:0]         k_cnt_reg;
  logic [FLUSH_CNT_WIDTH-1:0] flush_cnt_reg;
  logic [ROW_IDX_WIDTH-1:0]   row_idx_reg;

  logic in_ready;
  logic out_valid;
  logic busy;
  logic done;
  logic clear;
  logic load_step;
  logic flush_step;
  logic step;
  logic out_fire;

  // a_in[i][j] / b_in[i][j] are the operands presented to PE(i,j) on the current step
  logic signed [INPUT_WIDTH-1:0] row_in [M];
  logic signed [INPUT_WIDTH-1:0] col_in [N];
  logic signed [INPUT_WIDTH-1:0] a_in   [M][N];
  logic signed [INPUT_WIDTH-1:0] b_in   [M][N];
  logic signed [ACC_WIDTH-1:0]   acc    [M][N];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    clear      = 1'b0;
    flush_step = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (bus.start) begin
          clear      = 1'b1;
          state_next = (bus.k_len == '0) ? DRAIN : LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (bus.in_valid && (k_cnt_reg == k_len_reg - K_WIDTH'(1))) begin
          state_next = (FLUSH_LEN > 0) ? FLUSH : DRAIN;
        end
      end
      FLUSH: begin
        flush_step = 1'b1;
        if (flush_cnt_reg == FLUSH_CNT_WIDTH'(FLUSH_LEN - 1)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (bus.out_ready && (row_idx_reg == ROW_IDX_WIDTH'(M - 1))) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign load_step = bus.in_valid && in_ready;
  assign step      = load_step || flush_step;
  assign out_fire  = out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_len_reg     <= '0;
      k_cnt_reg     <= '0;
      flush_cnt_reg <= '0;
      row_idx_reg   <= '0;
    end else begin
      if (clear) begin
        k_len_reg     <= bus.k_len;
        k_cnt_reg     <= '0;
        flush_cnt_reg <= '0;
        row_idx_reg   <= '0;
      end
      if (load_step) begin
        k_cnt_reg <= k_cnt_reg + K_WIDTH'(1);
      end
      if (flush_step) begin
        flush_cnt_reg <= flush_cnt_reg + FLUSH_CNT_WIDTH'(1);
      end
      if (out_fire) begin
        row_idx_reg <= (row_idx_reg == ROW_IDX_WIDTH'(M - 1)) ? '0 : row_idx_reg + ROW_IDX_WIDTH'(1);
      end
    end
  end

  // Flush steps feed zeros so the tail of the wavefront adds nothing.
  genvar gi, gj;
  for (gi = 0; gi < M; gi++) begin : g_row_in
    assign row_in[gi] = load_step ? bus.in_row[gi*INPUT_WIDTH +: INPUT_WIDTH] : '0;
  end
  for (gj = 0; gj < N; gj++) begin : g_col_in
    assign col_in[gj] = load_step ? bus.in_col[gj*INPUT_WIDTH +: INPUT_WIDTH] : '0;
  end

  for (gi = 0; gi < M; gi++) begin : g_row_skew
    if (gi == 0) begin : g_direct
      assign a_in[gi][0] = row_in[gi];
    end else begin : g_delay
      logic signed [INPUT_WIDTH-1:0] line [gi];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int d = 0; d < gi; d++) line[d] <= '0;
        end else if (clear) begin
          for (int d = 0; d < gi; d++) line[d] <= '0;
        end else if (step) begin
          line[0] <= row_in[gi];
          for (int d = 1; d < gi; d++) line[d] <= line[d-1];
        end
      end
      assign a_in[gi][0] = line[gi-1];
    end
  end

  for (gj = 0; gj < N; gj++) begin : g_col_skew
    if (gj == 0) begin : g_direct
      assign b_in[0][gj] = col_in[gj];
    end else begin : g_delay
      logic signed [INPUT_WIDTH-1:0] line [gj];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int d = 0; d < gj; d++) line[d] <= '0;
        end else if (clear) begin
          for (int d = 0; d < gj; d++) line[d] <= '0;
        end else if (step) begin
          line[0] <= col_in[gj];
          for (int d = 1; d < gj; d++) line[d] <= line[d-1];
        end
      end
      assign b_in[0][gj] = line[gj-1];
    end
  end

  for (gi = 0; gi < M; gi++) begin : g_pe_row
    for (gj = 0; gj < N; gj++) begin : g_pe
      logic signed [PROD_WIDTH-1:0] prod;
      logic signed [ACC_WIDTH-1:0]  acc_q;

      assign prod = PROD_WIDTH'(a_in[gi][gj]) * PROD_WIDTH'(b_in[gi][gj]);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          acc_q <= '0;
        end else if (clear) begin
          acc_q <= '0;
        end else if (step) begin
          acc_q <= acc_q + ACC_WIDTH'(prod);
        end
      end
      assign acc[gi][gj] = acc_q;

      if (gj < N - 1) begin : g_a_pass
        logic signed [INPUT_WIDTH-1:0] a_q;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            a_q <= '0;
          end else if (clear) begin
            a_q <= '0;
          end else if (step) begin
            a_q <= a_in[gi][gj];
          end
        end
        assign a_in[gi][gj+1] = a_q;
      end

      if (gi < M - 1) begin : g_b_pass
        logic signed [INPUT_WIDTH-1:0] b_q;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            b_q <= '0;
          end else if (clear) begin
            b_q <= '0;
          end else if (step) begin
            b_q <= b_in[gi][gj];
          end
        end
        assign b_in[gi+1][gj] = b_q;
      end
    end
  end

  for (gj = 0; gj < N; gj++) begin : g_out
    assign bus.out_data[gj*ACC_WIDTH +: ACC_WIDTH] = out_valid ? acc[row_idx_reg][gj] : '0;
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_row_idx = row_idx_reg;
  assign bus.busy        = busy;
  assign bus.done        = done;
endmodule

// File: tb/tb_os_systolic_tile_seq.sv
// Directed bench for os_systolic_tile_seq: a matrix-product model predicts every drained row,
// a per-cycle monitor compares the result stream and done pulse against it.
module tb_os_systolic_tile_seq;
  localparam int M  = 4;
  localparam int N  = 4;
  localparam int IW = 8;
  localparam int AW = 16;
  localparam int KW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  os_systolic_tile_seq_if #(.M(M), .N(N), .INPUT_WIDTH(IW), .ACC_WIDTH(AW), .K_WIDTH(KW)) bus ();

  os_systolic_tile_seq #(.M(M), .N(N), .INPUT_WIDTH(IW), .ACC_WIDTH(AW), .K_WIDTH(KW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  int a_q [16][M];
  int b_q [16][N];
  logic signed [AW-1:0] exp_c [M][N];
  logic signed [AW-1:0] cap   [M][N];

  int exp_row   = 0;
  bit exp_done  = 1'b0;
  int rows_seen = 0;
  int done_cnt  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // C[i][j] = sum over k of A[i][k]*B[k][j], where vector k carries A column k and B row k
  function automatic void build_model(input int k);
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        longint s = 0;
        for (int t = 0; t < k; t++) s += longint'(a_q[t][i]) * longint'(b_q[t][j]);
        exp_c[i][j] = AW'(s);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      exp_row  = 0;
      exp_done = 1'b0;
    end else begin
      check("done_pulse", bus.done, exp_done);
      exp_done = 1'b0;
      if (bus.out_valid) begin
        check("row_idx", bus.out_row_idx, exp_row);
        for (int j = 0; j < N; j++) begin
          check("row_data", $signed(bus.out_data[j*AW +: AW]), exp_c[exp_row][j]);
        end
        if (bus.out_ready) begin
          for (int j = 0; j < N; j++) cap[exp_row][j] = bus.out_data[j*AW +: AW];
          $display("row %0d drained: %0d %0d %0d %0d", exp_row,
                   $signed(bus.out_data[0 +: AW]), $signed(bus.out_data[AW +: AW]),
                   $signed(bus.out_data[2*AW +: AW]), $signed(bus.out_data[3*AW +: AW]));
          rows_seen++;
          exp_done = (exp_row == M - 1);
          exp_row  = (exp_row + 1) % M;
        end
      end
      if (bus.done) done_cnt++;
    end
  end

  task automatic run_job(input int k, input int gap, input int stall_row, input int exp_lat);
    int rows0;
    int done0;
    build_model(k);
    rows0 = rows_seen;
    done0 = done_cnt;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.k_len = KW'(k);
    fork
      begin
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        for (int c = 0; c < 300 && !got; c++) begin
          @(posedge clk);
          lat++;
          @(negedge clk);
          if (bus.out_valid) got = 1'b1;
          else check("busy_hold", bus.busy, 1);
        end
        check("first_valid_seen", got, 1);
        if (exp_lat > 0) check("latency", lat, exp_lat);
      end
      begin
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int t = 0; t < k; t++) begin
          bit acc_ok;
          if (gap > 0 && t > 0) begin
            bus.in_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
          end
          for (int i = 0; i < M; i++) bus.in_row[i*IW +: IW] = IW'(a_q[t][i]);
          for (int j = 0; j < N; j++) bus.in_col[j*IW +: IW] = IW'(b_q[t][j]);
          bus.in_valid = 1'b1;
          acc_ok = 1'b0;
          for (int c = 0; c < 50 && !acc_ok; c++) begin
            @(negedge clk);
            if (bus.in_ready) acc_ok = 1'b1;
            @(posedge clk);
            #1;
          end
          check("in_accept", acc_ok, 1);
        end
        bus.in_valid = 1'b0;
      end
      begin
        bit fin;
        int stalls;
        fin    = 1'b0;
        stalls = 0;
        for (int c = 0; c < 400 && !fin; c++) begin
          @(posedge clk);
          #1;
          if (bus.done) fin = 1'b1;
          if (bus.out_valid && bus.out_row_idx == stall_row && stalls < 5) begin
            bus.out_ready = 1'b0;
            stalls++;
          end else begin
            bus.out_ready = 1'b1;
          end
        end
        check("done_seen", fin, 1);
        if (stall_row >= 0) check("stall_cycles", stalls, 5);
      end
    join
    @(posedge clk);
    #1;
    check("busy_idle", bus.busy, 0);
    check("rows_drained", rows_seen - rows0, M);
    check("done_count", done_cnt - done0, 1);
    $display("job k=%0d gap=%0d stall_row=%0d complete", k, gap, stall_row);
  endtask

  task automatic clear_ops();
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < M; i++) a_q[t][i] = 0;
      for (int j = 0; j < N; j++) b_q[t][j] = 0;
    end
  endtask

  task automatic load_identity_job();
    clear_ops();
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < M; i++) a_q[t][i] = (t == i) ? 1 : 0;
      for (int j = 0; j < N; j++) b_q[t][j] = 4 * t + j + 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int done0;
    bus.start     = 1'b0;
    bus.k_len     = '0;
    bus.in_valid  = 1'b0;
    bus.in_row    = '0;
    bus.in_col    = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_row_idx", bus.out_row_idx, 0);
    check("rst_out_data", longint'(bus.out_data), 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    $display("reset state checked");
    @(posedge clk);
    #1;
    rst = 1'b1;

    clear_ops();
    a_q[0][0] = 3;
    a_q[0][1] = -2;
    b_q[0][0] = 4;
    b_q[0][1] = 5;
    run_job(1, 0, -1, 8);
    check("lit_c00", cap[0][0], 12);
    check("lit_c01", cap[0][1], 15);
    check("lit_c10", cap[1][0], -8);
    check("lit_c11", cap[1][1], -10);
    check("lit_c33", cap[3][3], 0);

    load_identity_job();
    run_job(4, 0, -1, 11);
    check("lit_id_c00", cap[0][0], 1);
    check("lit_id_c21", cap[2][1], 10);
    check("lit_id_c33", cap[3][3], 16);

    load_identity_job();
    run_job(4, 1, -1, 14);
    check("lit_gap_c12", cap[1][2], 7);

    load_identity_job();
    run_job(4, 0, 1, 11);
    check("lit_stall_c13", cap[1][3], 8);

    clear_ops();
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < M; i++) a_q[t][i] = 127;
      for (int j = 0; j < N; j++) b_q[t][j] = 127;
    end
    run_job(5, 0, -1, 12);
    check("lit_wrap_c00", cap[0][0], 15109);
    check("lit_wrap_c32", cap[3][2], 15109);

    clear_ops();
    run_job(0, 0, -1, 0);
    check("lit_zero_c00", cap[0][0], 0);
    check("lit_zero_c23", cap[2][3], 0);

    done0 = done_cnt;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.k_len = KW'(4);
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.in_row   = {M{8'sd100}};
    bus.in_col   = {N{8'sd100}};
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_in_ready", bus.in_ready, 0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_out_data", longint'(bus.out_data), 0);
    check("abort_done", bus.done, 0);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - done0, 0);
    $display("mid-load reset checked");

    load_identity_job();
    run_job(4, 0, -1, 11);
    check("lit_post_abort_c11", cap[1][1], 6);
    check("lit_post_abort_c30", cap[3][0], 13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/os_systolic_tile_seq.md
Name: os_systolic_tile_seq

Overview:
Output-stationary M x N systolic tile with its own sequencer. It accepts K streamed row/column operand vectors over a valid/ready handshake and applies the diagonal input skew internally. It accumulates C = A x B in per-PE accumulators, flushes the pipeline, then drains results one row per handshake. It is the next-generation compute tile that a top-level TPU controller drives through a start/done interface.

Parameters:
M, 8, number of PE rows (length of in_row vector)
N, 8, number of PE columns (length of in_col vector)
INPUT_WIDTH, 16, signed operand width
ACC_WIDTH, 40, signed accumulator width (must be >= 2*INPUT_WIDTH)
K_WIDTH, 16, width of the k_len command field

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous reset, active low
start  in  1  one-cycle command pulse; sampled only in IDLE
k_len  in  K_WIDTH  number of operand vectors for this job; sampled with start
in_valid  in  1  operand vector valid
in_ready  out  1  tile accepts operand vector
in_row  in  M*INPUT_WIDTH  A column slice; element i at bits [i*INPUT_WIDTH +: INPUT_WIDTH], ascending [0:...] ordering
in_col  in  N*INPUT_WIDTH  B row slice; element j at bits [j*INPUT_WIDTH +: INPUT_WIDTH]
out_valid  out  1  result row valid
out_ready  in  1  downstream accepts result row
out_row_idx  out  $clog2(M) (min 1)  index of row on out_data
out_data  out  N*ACC_WIDTH  C[row][j] at bits [j*ACC_WIDTH +: ACC_WIDTH]
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse after the last row handshake

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, all skew registers, PE pipeline registers and accumulators = 0. Outputs in_ready=0, out_valid=0, out_row_idx=0, out_data=0, busy=0, done=0. Reset mid-job aborts the job; no done pulse.
- States: IDLE, LOAD, FLUSH, DRAIN, DONE.
- IDLE: start=1 latches k_len and clears all accumulators and skew/pipe registers.
  - k_len>0 -> LOAD.
  - k_len=0 -> DRAIN (all-zero results).
- start while busy is ignored.
- LOAD: in_ready=1. The array, skew and PEs advance only on a cycle with in_valid && in_ready ("step"). With no step, everything holds, so gaps in in_valid do not change the result. After the k_len-th accepted vector -> FLUSH.
- Skew: row element i is delayed i steps; column element j is delayed j steps. Zero-filled delay lines.
- PE(i,j):
  - a passes rightward and b passes downward with 1 step of delay each.
  - acc += a*b: signed multiply, sign-extended to ACC_WIDTH, wraps modulo 2^ACC_WIDTH with no saturation.
- FLUSH: in_ready=0. The array steps every cycle with zero inputs for exactly M+N-2 cycles, then -> DRAIN. For M=N=1, FLUSH lasts 0 cycles and goes directly to DRAIN.
- DRAIN:
  - out_valid=1, out_data = accumulator row out_row_idx, starting at 0.
  - On out_valid && out_ready: out_row_idx increments.
  - After handshake on row M-1 -> DONE.
  - out_data and out_row_idx remain stable while out_valid && !out_ready.
- DONE: done=1 for one cycle, out_valid=0, out_row_idx=0 -> IDLE.
- Accumulators retain values in IDLE until the next start.
- Latency (no stalls, out_ready=1): the first result row appears k_len + M+N-2 + 1 cycles after the start cycle.

Test Plan:
- M=N=2, INPUT_WIDTH=8, ACC_WIDTH=24; start, k_len=1, in_row=(3,-2), in_col=(4,5) -> rows (12,15) and (-8,-10). done pulses one cycle after the row-1 handshake.
- M=N=4 defaults; k_len=4, A=identity, B=values 1..16 row-major -> drained rows equal B rows exactly. First out_valid at cycle 4+6+1=11 after start.
- Same as the previous case with in_valid deasserted for 3 random cycles between vectors -> identical results; busy held high throughout.
- DRAIN with out_ready low for 5 cycles on row 1 -> out_data and out_row_idx frozen; no row skipped or duplicated.
- INPUT_WIDTH=8, ACC_WIDTH=16; k_len=5 of 127*127 -> 80645 mod 65536 = 15109 in every PE. Separately, k_len=0 -> M all-zero rows, then done.
- Assert rst low during LOAD after 2 vectors -> all outputs 0 immediately, no done pulse. A following fresh job produces correct results uncontaminated by the prior partial sums.
